// File: rtl/spi_memory_burst_if.sv
// Serial frame bus between a host and the burst register memory.
`timescale 1ns/1ps
interface spi_memory_burst_if;
    logic cs;
    logic miso;
    logic mosi;
    logic ready;
    logic op_done;
    logic abort;
    logic busy;

    modport master (
        output cs,
        output miso,
        input  mosi,
        input  ready,
        input  op_done,
        input  abort,
        input  busy
    );

    modport slave (
        input  cs,
        input  miso,
        output mosi,
        output ready,
        output op_done,
        output abort,
        output busy
    );
endinterface

// File: rtl/spi_memory_burst.sv
// Serial-access register memory with single and burst read/write frames,
// address auto-increment with wrap, and abort on early cs release.
`timescale 1ns/1ps
module spi_memory_burst #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    spi_memory_burst_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned WC_W  = LEN_W + 1;
    localparam int unsigned MAX_F = (DATA_W > ADDR_W) ?
                                    ((DATA_W > LEN_W) ? DATA_W : LEN_W) :
                                    ((ADDR_W > LEN_W) ? ADDR_W : LEN_W);
    localparam int unsigned CNT_W = $clog2(MAX_F);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_LEN,
        S_WDATA,
        S_RLOAD,
        S_RDATA,
        S_WAIT_CS
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  d_out_q, d_out_d;
    logic               mosi_q, mosi_d;
    logic               ready_q, ready_d;
    logic               op_done_q, op_done_d;
    logic               abort_q, abort_d;
    logic               busy_q, busy_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               mem_we_c;
    logic [DATA_W-1:0]  mem_wdata_c;
    logic [ADDR_W-1:0]  addr_inc_c;
    logic [WC_W-1:0]    word_inc_c;
    logic [WC_W-1:0]    words_total_c;
    logic [CNT_W-1:0]   cnt_inc_c;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        d_out_d    = d_out_q;
        mosi_d     = 1'b0;
        ready_d    = 1'b0;
        op_done_d  = 1'b0;
        abort_d    = 1'b0;
        mem_we_c   = 1'b0;

        mem_wdata_c   = DATA_W'({bus.miso, shift_q} >> 1);
        addr_inc_c    = addr_q + ADDR_W'(1);
        word_inc_c    = word_cnt_q + WC_W'(1);
        words_total_c = {1'b0, len_q} + WC_W'(1);
        cnt_inc_c     = cnt_q + CNT_W'(1);

        if ((state_q inside {S_CMD, S_ADDR, S_LEN, S_WDATA, S_RLOAD, S_RDATA}) && bus.cs) begin
            // Early cs release: drop everything in flight and return to idle.
            state_d = S_IDLE;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.cs) begin
                        state_d    = S_CMD;
                        cnt_d      = '0;
                        word_cnt_d = '0;
                        len_d      = '0;
                    end
                end
                S_CMD: begin
                    op_d = {bus.miso, op_q[1]};
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_ADDR;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                S_ADDR: begin
                    addr_d = ADDR_W'({bus.miso, addr_q} >> 1);
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        cnt_d = '0;
                        if (op_q[1]) begin
                            state_d = S_LEN;
                        end else begin
                            len_d   = '0;
                            state_d = op_q[0] ? S_WDATA : S_RLOAD;
                        end
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                S_LEN: begin
                    len_d = LEN_W'({bus.miso, len_q} >> 1);
                    if (cnt_q == CNT_W'(LEN_W - 1)) begin
                        cnt_d   = '0;
                        state_d = op_q[0] ? S_WDATA : S_RLOAD;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                S_WDATA: begin
                    shift_d = mem_wdata_c;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        mem_we_c   = 1'b1;
                        addr_d     = addr_inc_c;
                        cnt_d      = '0;
                        word_cnt_d = word_inc_c;
                        if (word_inc_c == words_total_c) begin
                            state_d   = S_WAIT_CS;
                            op_done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                S_RLOAD: begin
                    ready_d = 1'b1;
                    d_out_d = mem_q[addr_q];
                    cnt_d   = '0;
                    state_d = S_RDATA;
                end
                S_RDATA: begin
                    if (word_cnt_q == words_total_c) begin
                        // Last bit of the final word has been on mosi for a cycle.
                        state_d   = S_WAIT_CS;
                        op_done_d = 1'b1;
                    end else begin
                        mosi_d = d_out_q[cnt_q];
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            cnt_d      = '0;
                            addr_d     = addr_inc_c;
                            d_out_d    = mem_q[addr_inc_c];
                            word_cnt_d = word_inc_c;
                        end else begin
                            cnt_d = cnt_inc_c;
                        end
                    end
                end
                S_WAIT_CS: begin
                    if (bus.cs) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            d_out_q    <= '0;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b0;
            op_done_q  <= 1'b0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
            d_out_q    <= d_out_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            op_done_q  <= op_done_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[addr_q] <= mem_wdata_c;
        end
    end

    assign bus.mosi    = mosi_q;
    assign bus.ready   = ready_q;
    assign bus.op_done = op_done_q;
    assign bus.abort   = abort_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_spi_memory_burst.sv
// Directed bench for spi_memory_burst: single/burst frames, wrap, abort,
// held cs and asynchronous reset during a read.
`timescale 1ns/1ps
module tb_spi_memory_burst;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [7:0] wbuf [16];
    logic [7:0] rexp [16];

    spi_memory_burst_if bus ();

    spi_memory_burst #(
        .DATA_W (8),
        .ADDR_W (5),
        .LEN_W  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit period; returns at the following falling edge.
    task automatic cyc(input logic c, input logic d);
        bus.cs   = c;
        bus.miso = d;
        @(negedge clk);
    endtask

    task automatic frame_hdr(input logic [1:0] op, input logic [4:0] a, input logic [3:0] len);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, op[i]);
        for (int i = 0; i < 5; i++) cyc(1'b0, a[i]);
        if (op[1]) begin
            for (int i = 0; i < 4; i++) cyc(1'b0, len[i]);
        end
    endtask

    task automatic write_frame(input logic burst, input logic [4:0] a, input int nw, input string tag);
        int pulses;
        pulses = 0;
        frame_hdr({burst, 1'b1}, a, 4'(nw - 1));
        chk({tag, "/busy"}, 32'(bus.busy), 32'd1);
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 8; b++) begin
                cyc(1'b0, wbuf[w][b]);
                pulses += int'(bus.op_done);
            end
        end
        chk({tag, "/op_done"}, 32'(bus.op_done), 32'd1);
        cyc(1'b0, 1'b0);
        pulses += int'(bus.op_done);
        chk({tag, "/op_done_pulses"}, 32'(pulses), 32'd1);
        cyc(1'b1, 1'b0);
        chk({tag, "/idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic read_frame(input logic burst, input logic [4:0] a, input int nw, input string tag);
        int extra;
        logic [7:0] got;
        extra = 0;
        frame_hdr({burst, 1'b0}, a, 4'(nw - 1));
        cyc(1'b0, 1'b0);
        chk({tag, "/ready"}, 32'(bus.ready), 32'd1);
        for (int w = 0; w < nw; w++) begin
            got = 8'h00;
            for (int b = 0; b < 8; b++) begin
                cyc(1'b0, 1'b0);
                got[b] = bus.mosi;
                extra += int'(bus.ready | bus.op_done);
            end
            chk({tag, "/word"}, 32'(got), 32'(rexp[w]));
        end
        cyc(1'b0, 1'b0);
        chk({tag, "/done_mosi"}, 32'({bus.op_done, bus.mosi}), 32'b10);
        chk({tag, "/no_extra_pulse"}, 32'(extra), 32'd0);
        cyc(1'b1, 1'b0);
        chk({tag, "/idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int extra;
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b0;
        bus.cs   = 1'b1;
        bus.miso = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("reset_outputs", 32'({bus.mosi, bus.ready, bus.op_done, bus.abort, bus.busy}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, 1'b0);

        // Single write 0xA5 @3, single read back.
        wbuf[0] = 8'hA5;
        write_frame(1'b0, 5'd3, 1, "wr3");
        rexp[0] = 8'hA5;
        read_frame(1'b0, 5'd3, 1, "rd3");

        // Burst write across the top of the address space.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        write_frame(1'b1, 5'd30, 4, "bwr30");
        rexp[0] = 8'h11; read_frame(1'b0, 5'd30, 1, "rd30");
        rexp[0] = 8'h22; read_frame(1'b0, 5'd31, 1, "rd31");
        rexp[0] = 8'h33; read_frame(1'b0, 5'd0,  1, "rd0");
        rexp[0] = 8'h44; read_frame(1'b0, 5'd1,  1, "rd1");

        // Burst read with wrap.
        rexp[0] = 8'h11; rexp[1] = 8'h22; rexp[2] = 8'h33; rexp[3] = 8'h44;
        read_frame(1'b1, 5'd30, 4, "brd30");

        // Abort in the middle of the second burst word.
        wbuf[0] = 8'hC3;
        write_frame(1'b0, 5'd6, 1, "wr6");
        frame_hdr(2'b11, 5'd5, 4'd1);
        for (int b = 0; b < 8; b++) cyc(1'b0, b[0] ? 1'b1 : 1'b0);
        for (int b = 0; b < 8; b++) begin
            // 0x5A = 0,1,0,1,1,0,1,0 LSB first
        end
        for (int b = 0; b < 4; b++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        chk("abort/pulse", 32'(bus.abort), 32'd1);
        chk("abort/idle", 32'({bus.busy, bus.op_done, bus.mosi}), 32'd0);
        cyc(1'b1, 1'b0);
        chk("abort/one_cycle", 32'(bus.abort), 32'd0);
        rexp[0] = 8'hAA; read_frame(1'b0, 5'd5, 1, "rd5_after_abort");
        rexp[0] = 8'hC3; read_frame(1'b0, 5'd6, 1, "rd6_after_abort");

        // Burst word 0 = 0x5A completes, word 1 cut after 4 bits.
        frame_hdr(2'b11, 5'd5, 4'd1);
        wbuf[0] = 8'h5A;
        for (int b = 0; b < 8; b++) cyc(1'b0, wbuf[0][b]);
        for (int b = 0; b < 4; b++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        chk("abort2/pulse", 32'({bus.abort, bus.busy}), 32'b10);
        cyc(1'b1, 1'b0);
        rexp[0] = 8'h5A; read_frame(1'b0, 5'd5, 1, "rd5_after_abort2");
        rexp[0] = 8'hC3; read_frame(1'b0, 5'd6, 1, "rd6_after_abort2");

        // cs held low after completion: no new frame may start.
        wbuf[0] = 8'h3C;
        frame_hdr(2'b01, 5'd9, 4'd0);
        for (int b = 0; b < 8; b++) cyc(1'b0, wbuf[0][b]);
        chk("held/op_done", 32'(bus.op_done), 32'd1);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, i[0]);
            extra += int'(bus.ready | bus.op_done | bus.abort);
        end
        chk("held/busy", 32'(bus.busy), 32'd1);
        chk("held/no_pulses", 32'(extra), 32'd0);
        cyc(1'b1, 1'b0);
        chk("held/release", 32'(bus.busy), 32'd0);
        rexp[0] = 8'h3C; read_frame(1'b0, 5'd9, 1, "rd9");

        // Asynchronous reset while streaming read data.
        frame_hdr(2'b00, 5'd3, 4'd0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("rst_rd/mosi_bit0", 32'({bus.mosi, bus.busy}), 32'b11);
        #1 reset = 1'b1;
        #1;
        chk("rst_rd/outputs", 32'({bus.mosi, bus.ready, bus.op_done, bus.abort, bus.busy}), 32'd0);
        bus.cs = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, 1'b0);
        rexp[0] = 8'hA5; read_frame(1'b0, 5'd3, 1, "rd3_after_rst");
        rexp[0] = 8'h44; read_frame(1'b0, 5'd1, 1, "rd1_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_memory_burst.md
# spi_memory_burst

Parametrised serial-access register memory with single and burst read/write transactions. It is the successor to the 8-bit × 32 serial memory slave. Memory width, depth and burst length are set by parameters, and the block adds a 2-bit opcode, burst transfers with address auto-increment and wrap, and a clean abort when `cs` rises mid-frame. All serial bits are sampled and driven on the system clock; there is no separate serial clock.

## Interface
- `DATA_W`, default 8: memory word width in bits (≥2).
- `ADDR_W`, default 5: address width; `DEPTH = 2**ADDR_W` words.
- `LEN_W`, default 4: burst length field width; a burst moves `len+1` words (1..2**LEN_W).
- `clk`  in  1: system clock. All logic on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `cs`  in  1: frame select, active low.
- `miso`  in  1: serial data into the block, LSB first.
- `mosi`  out  1: serial read data out of the block, LSB first.
- `ready`  out  1: one-cycle pulse; the first read word is loaded and serial output starts next cycle.
- `op_done`  out  1: one-cycle pulse on successful completion of a transaction.
- `abort`  out  1: one-cycle pulse when `cs` rises before the transaction completes.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Reset (asynchronous): state=IDLE, all counters 0, and `mosi`, `ready`, `op_done`, `abort`, `busy` all 0. Memory array is not reset; contents are undefined until written.
- Frame format, each field LSB first, one bit per `clk`:
  - op[1:0]: 00 = single read, 01 = single write, 10 = burst read, 11 = burst write.
  - addr[ADDR_W-1:0].
  - len[LEN_W-1:0], burst opcodes only. Single ops use len=0 implicitly.
  - Write data: `len+1` words of DATA_W bits each.
- States: IDLE, CMD, ADDR, LEN, WDATA, RLOAD, RDATA, WAIT_CS.
  - IDLE: `cs`=0 → CMD.
  - CMD: collects 2 bits, then → ADDR.
  - ADDR: collects ADDR_W bits, then → LEN (burst) or → WDATA/RLOAD (single).
  - LEN: collects LEN_W bits, then → WDATA or RLOAD.
  - WDATA: on the edge sampling the last bit of a word, write `mem[addr] <= {miso, shift[DATA_W-1:1]}`, then `addr <= addr+1`.
    - Words remaining → stay in WDATA with no gap.
    - Otherwise → WAIT_CS with `op_done`=1.
  - RLOAD: one cycle. `ready`=1 and `d_out <= mem[addr]`, then → RDATA.
  - RDATA: `mosi <= d_out[bit]` each cycle.
    - After the last bit of a word, `d_out <= mem[addr+1]` and `addr` increments. The next word starts on the following cycle with no gap.
    - After the final word's last bit has been driven for one cycle → WAIT_CS with `op_done`=1 and `mosi`=0.
  - WAIT_CS: stays until `cs`=1, then → IDLE. A new frame requires `cs` to go high, then low again.
- Address arithmetic is modulo DEPTH: address DEPTH-1 increments to 0. The word counter is LEN_W+1 bits wide, so len = all-ones does not overflow.
- Abort: `cs`=1 sampled in CMD/ADDR/LEN/WDATA/RLOAD/RDATA → IDLE next edge.
  - `abort`=1 for one cycle and `mosi`=0.
  - A partially received word is discarded; completed burst words stay written.
  - `cs`=1 in WAIT_CS is normal exit and does not abort.
- `ready` and `op_done` never assert in the same cycle. `abort` and `op_done` are mutually exclusive.

## Timing
- Edge E0: IDLE samples `cs`=0. Op bits are sampled at E1–E2 and address bits at E3..E(2+ADDR_W).
- Default parameters, single write:
  - Data bits sampled at E8–E15; memory updated at E15.
  - `op_done` high in the cycle after E15.
- Default parameters, single read:
  - `ready` high after E8.
  - `mosi` carries bit0..bit7 after E9..E16.
  - `op_done`=1 and `mosi`=0 after E17.
- Bursts: the len field occupies E8–E11, and all later events shift by LEN_W cycles. Words are back-to-back, DATA_W cycles each.
- `busy` rises after E0 and falls on the edge that returns the state to IDLE.
- Reset mid-frame: outputs go to 0 immediately, independent of `clk`.

## Test plan
- Single write then single read: write 0xA5 to address 3, then read address 3. Expect `op_done` pulse after the write. On the read, `ready` after E8, `mosi` = 1,0,1,0,0,1,0,1 over E9–E16, then `op_done`.
- Burst write with wrap: address 30, len=3, data 0x11, 0x22, 0x33, 0x44. Reading back single addresses 30, 31, 0, 1 returns 0x11, 0x22, 0x33, 0x44. One `op_done` for the burst.
- Burst read: read address 30 with len=3 after the previous test. `mosi` streams 32 bits equal to 0x11, 0x22, 0x33, 0x44 LSB first with no gap. `ready` pulses once, then `op_done`.
- Abort mid-word: burst write at address 5 with len=1; word 0 = 0x5A completes, then `cs` rises after 4 bits of word 1. Expect `abort` pulse, state IDLE, `mem[5]`=0x5A, `mem[6]` unchanged.
- Held `cs`: keep `cs` low after `op_done`. No new transaction starts and `busy` stays 1 until `cs`=1.
- Asynchronous reset asserted during RDATA: `mosi`, `ready`, `op_done`, `abort`, `busy` all 0 before the next `clk` edge. A subsequent read returns previously written data.
